// File: rtl/combi_sweep_ctrl.sv
// Exhaustive truth-table sweeper for a small N-input, 1-output combinational block.
// Drives every input vector in ascending order, samples Y after a settle window, and compares against a latched table.
module combi_sweep_ctrl #(
  parameter int N          = 3,
  parameter int SETTLE_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [(1<<N)-1:0] exp_tt,
  input  logic              y_in,
  output logic [N-1:0]      stim,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [(1<<N)-1:0] obs_tt,
  output logic [N:0]        fail_cnt,
  output logic [N-1:0]      first_fail
);
  localparam int TT = 1 << N;
  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  state_t          state, state_nxt;
  logic [N-1:0]    idx;
  logic [CW-1:0]   cnt;
  logic [TT-1:0]   exp_l;
  logic            mism, last;

  assign mism = exp_l[idx] ^ y_in;
  assign last = (idx == {N{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stim      = '0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:   if (start && !abort) state_nxt = SETTLE;
      SETTLE: begin
        stim = idx;
        busy = 1'b1;
        if (abort)          state_nxt = IDLE;
        else if (cnt == '0) state_nxt = SAMPLE;
      end
      SAMPLE: begin
        stim = idx;
        busy = 1'b1;
        if (abort)     state_nxt = IDLE;
        else if (last) state_nxt = DONE;
        else           state_nxt = SETTLE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: results persist past DONE; an abort simply freezes the partial tally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      cnt        <= '0;
      exp_l      <= '0;
      obs_tt     <= '0;
      fail_cnt   <= '0;
      first_fail <= '0;
      pass       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start && !abort) begin
          exp_l      <= exp_tt;
          obs_tt     <= '0;
          fail_cnt   <= '0;
          first_fail <= '0;
          pass       <= 1'b0;
          idx        <= '0;
          cnt        <= CNT_LOAD;
        end
        SETTLE: if (!abort && cnt != '0) cnt <= cnt - CW'(1);
        SAMPLE: if (!abort) begin
          obs_tt[idx] <= y_in;
          if (mism) begin
            fail_cnt <= fail_cnt + (N+1)'(1);
            if (fail_cnt == '0) first_fail <= idx;
          end
          if (last) pass <= (fail_cnt == '0) && !mism;
          else begin
            idx <= idx + N'(1);
            cnt <= CNT_LOAD;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
